uart_tx_io: RTL and testbench

- Memory-mapped UART transmitter that lets the running CPU send bytes to the host PC over the serial line.
- Complement of the UART programmer's receive path: serial out, 8N1 (8 data bits, no parity, 1 stop bit), LSB first.
- Sits on the CPU IO bus in the cpuclk domain next to the existing IO peripherals.
- CPU stores to the data register push bytes into a small FIFO; a baud-timed FSM drains the FIFO onto `tx`.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_io_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_io.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_io.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4)
//   - STATUS register bit positions
//   - IO address decode values for the DATA and STATUS registers
// The PARITY encoding is always reserved; it is only reachable when the
// design is built with UART_TX_PARITY_EN defined.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StStart  = ST_START,
        StData   = ST_DATA,
        StStop   = ST_STOP,
        StParity = ST_PARITY
    } tx_state_e;

    // STATUS register layout; the count field starts at STAT_CNT_LSB.
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;
    localparam int unsigned STAT_PARITY  = 31;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

endpackage

// File: rtl/uart_tx_io_if.sv
// CPU IO bus slice seen by the UART transmitter.
//   io_sel   : peripheral selected this cycle
//   io_wen   : write strobe (qualified by io_sel)
//   io_ren   : read strobe (qualified by io_sel)
//   io_addr  : 0 = DATA, 1 = STATUS
//   io_wdata : byte to transmit
//   io_rdata : combinational read data from the peripheral
interface uart_tx_io_if;

    logic        io_sel;
    logic        io_wen;
    logic        io_ren;
    logic        io_addr;
    logic [7:0]  io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output io_sel, io_wen, io_ren, io_addr, io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_sel, io_wen, io_ren, io_addr, io_wdata,
        output io_rdata
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata; accepted when not full, or when full with a pop
//   pop      : discard head; ignored when empty
//   rdata    : current head (combinational)
//   full, empty, count : occupancy, count in 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             wr, rd;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rptr_q];

    // A pop on the same edge frees the slot the push lands in.
    assign wr = push & (~full | pop);
    assign rd = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (rd) rptr_q <= rptr_q + AW'(1);
            if (wr && !rd)      count_q <= count_q + (AW + 1)'(1);
            else if (rd && !wr) count_q <= count_q - (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter on the CPU IO bus (cpuclk domain).
// Stores to DATA queue a byte; a baud-timed FSM shifts it out LSB first.
//   cpuclk  : system clock
//   rst     : synchronous active-high reset (aborts any frame in flight)
//   io      : IO bus slave port (DATA write, STATUS read/clear-overflow)
//   tx      : registered serial output, idle high
//   tx_busy : FSM not idle or FIFO non-empty
// Build option UART_TX_PARITY_EN adds an even-parity bit after the data bits
// and sets STATUS[31].
module uart_tx_io
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 199,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic         cpuclk,
    input  logic         rst,
    uart_tx_io_if.slave  io,
    output logic         tx,
    output logic         tx_busy
);

    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic          push, pop, status_rd, bit_end;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    assign push      = io.io_sel & io.io_wen & (io.io_addr == ADDR_DATA);
    assign status_rd = io.io_sel & io.io_ren & (io.io_addr == ADDR_STATUS);
    assign bit_end   = (cnt_q == CNT_MAX);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (cpuclk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (io.io_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = '0;
                    state_d = StStart;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^fifo_rdata;
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next frame when more is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = StStart;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^fifo_rdata;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // tx follows the state being entered so it changes on the same edge.
        tx_d = 1'b1;
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        // Overflow set takes priority over a concurrent STATUS read clear.
        ovf_d = ovf_q;
        if (status_rd)                   ovf_d = 1'b0;
        if (push && fifo_full && !pop)   ovf_d = 1'b1;
    end

    always_ff @(posedge cpuclk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != StIdle) | ~fifo_empty;

    always_comb begin
        status                          = '0;
        status[STAT_BUSY]               = tx_busy;
        status[STAT_FULL]               = fifo_full;
        status[STAT_EMPTY]              = fifo_empty;
        status[STAT_OVF]                = ovf_q;
        status[STAT_CNT_LSB +: CW]      = fifo_count;
`ifdef UART_TX_PARITY_EN
        status[STAT_PARITY]             = 1'b1;
`endif
    end

    assign io.io_rdata = (io.io_addr == ADDR_STATUS) ? status : '0;

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io with CLKS_PER_BIT=4, FIFO_DEPTH=4. Expected bytes go
// into exp_q as they are written; a serial monitor decodes tx into rx_q.
module tb_uart_tx_io;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME = 11 * CPB;
    localparam logic [31:0] BUILD = 32'h8000_0000;
`else
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BUILD = 32'h0000_0000;
`endif

    typedef struct {
        logic [7:0] data;
        int         start;
        logic       framing_ok;
        logic       par;
    } frame_t;

    logic cpuclk = 1'b0;
    logic rst    = 1'b1;
    logic tx, tx_busy;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] exp_q [$];
    frame_t     rx_q  [$];

    uart_tx_io_if bus ();

    uart_tx_io #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .cpuclk  (cpuclk),
        .rst     (rst),
        .io      (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 cpuclk = ~cpuclk;
    always @(posedge cpuclk) cyc <= cyc + 1;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Serial monitor: samples 1 time unit after each edge, bit centre at offset CPB/2.
    initial begin : monitor
        frame_t f;
        logic   abort;
        int     idx;
        forever begin
            @(posedge cpuclk); #1;
            if (!rst && tx === 1'b0) begin
                f.start = cyc; f.data = '0; f.framing_ok = 1'b1; f.par = 1'b0;
                abort = 1'b0;
                for (int s = 1; s < FRAME && !abort; s++) begin
                    @(posedge cpuclk); #1;
                    if (rst) begin
                        abort = 1'b1;
                    end else begin
                        if (s < CPB && tx !== 1'b0) f.framing_ok = 1'b0;
                        if (s >= CPB && s < 9 * CPB && (s % CPB) == CPB / 2) begin
                            idx = (s - CPB) / CPB;
                            f.data[idx[2:0]] = tx;
                        end
                        if (s >= 9 * CPB && s < 10 * CPB && (s % CPB) == CPB / 2) f.par = tx;
                        if (s >= FRAME - CPB && tx !== 1'b1) f.framing_ok = 1'b0;
                    end
                end
                if (!abort) rx_q.push_back(f);
            end
        end
    end

    task automatic idle_bus();
        bus.io_sel = 1'b0; bus.io_wen = 1'b0; bus.io_ren = 1'b0;
        bus.io_addr = 1'b0; bus.io_wdata = 8'h00;
    endtask

    task automatic cpu_write(input logic addr, input logic [7:0] d);
        @(negedge cpuclk);
        bus.io_sel = 1'b1; bus.io_wen = 1'b1; bus.io_ren = 1'b0;
        bus.io_addr = addr; bus.io_wdata = d;
        @(posedge cpuclk); #1;
        idle_bus();
    endtask

    task automatic cpu_read(input logic addr, output logic [31:0] v);
        @(negedge cpuclk);
        bus.io_sel = 1'b1; bus.io_wen = 1'b0; bus.io_ren = 1'b1; bus.io_addr = addr;
        #1 v = bus.io_rdata;
        @(posedge cpuclk); #1;
        idle_bus();
    endtask

    task automatic wait_frames(input int n, input int limit);
        for (int t = 0; t < limit && rx_q.size() < n; t++) begin
            @(posedge cpuclk); #2;
        end
    endtask

    task automatic wait_not_busy(input int limit);
        for (int t = 0; t < limit && tx_busy !== 1'b0; t++) begin
            @(posedge cpuclk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        idle_bus();
        rst = 1'b1;
        repeat (3) @(posedge cpuclk);
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        @(negedge cpuclk) rst = 1'b0;
        cpu_read(1'b1, v);
        checks++;
        if (v !== (32'h4 | BUILD)) begin errors++; $display("FAIL reset_status: got %h want %h", v, 32'h4 | BUILD); end
        cpu_read(1'b0, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL data_read: got %h want 0", v); end
    endtask

    task automatic test_status_write_ignored();
        logic [31:0] v;
        cpu_write(1'b1, 8'hAA);
        repeat (2 * FRAME) @(posedge cpuclk);
        #2;
        checks++;
        if (rx_q.size() != 0) begin errors++; $display("FAIL status_write_frames: got %0d want 0", rx_q.size()); end
        cpu_read(1'b1, v);
        checks++;
        if (v !== (32'h4 | BUILD)) begin errors++; $display("FAIL status_write_status: got %h want %h", v, 32'h4 | BUILD); end
    endtask

    task automatic test_single();
        int w;
        frame_t f;
        logic [7:0] e;
        exp_q.push_back(8'h55);
        cpu_write(1'b0, 8'h55);
        w = cyc;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_at_push: got %b want 1", tx); end
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", tx_busy); end
        @(posedge cpuclk); #1;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL single_start_edge: got %b want 0", tx); end
        wait_frames(1, FRAME + 20);
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL single_count: got %0d frames want 1", rx_q.size());
        end else begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (f.data !== e) begin errors++; $display("FAIL single_data: got %h want %h", f.data, e); end
            checks++;
            if (f.start != w + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", f.start, w + 1); end
            checks++;
            if (f.framing_ok !== 1'b1) begin errors++; $display("FAIL single_framing: got %b want 1", f.framing_ok); end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (f.par !== ^e) begin errors++; $display("FAIL single_parity: got %b want %b", f.par, ^e); end
`endif
        end
        wait_not_busy(FRAME + 20);
        checks++;
        if (cyc != w + 1 + FRAME) begin errors++; $display("FAIL single_busy_fall: got cycle %0d want %0d", cyc, w + 1 + FRAME); end
    endtask

    task automatic test_back_to_back();
        int w;
        frame_t f1, f2;
        logic [7:0] e1, e2;
        exp_q.push_back(8'hA3); exp_q.push_back(8'h0F);
        cpu_write(1'b0, 8'hA3);
        w = cyc;
        cpu_write(1'b0, 8'h0F);
        wait_frames(2, 2 * FRAME + 20);
        checks++;
        if (rx_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d frames want 2", rx_q.size());
            rx_q.delete(); exp_q.delete();
        end else begin
            f1 = rx_q.pop_front(); f2 = rx_q.pop_front();
            e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
            checks++;
            if (f1.data !== e1) begin errors++; $display("FAIL b2b_data0: got %h want %h", f1.data, e1); end
            checks++;
            if (f2.data !== e2) begin errors++; $display("FAIL b2b_data1: got %h want %h", f2.data, e2); end
            checks++;
            if (f1.start != w + 1) begin errors++; $display("FAIL b2b_start0: got %0d want %0d", f1.start, w + 1); end
            checks++;
            if (f2.start != f1.start + FRAME) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", f2.start, f1.start + FRAME); end
            checks++;
            if (f1.framing_ok !== 1'b1 || f2.framing_ok !== 1'b1) begin
                errors++; $display("FAIL b2b_framing: got %b%b want 11", f1.framing_ok, f2.framing_ok);
            end
            wait_not_busy(FRAME + 20);
            checks++;
            if (cyc != f1.start + 2 * FRAME) begin errors++; $display("FAIL b2b_busy_fall: got %0d want %0d", cyc, f1.start + 2 * FRAME); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        frame_t f;
        logic [7:0] e;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'h10 + 8'(i));
            cpu_write(1'b0, 8'h10 + 8'(i));
        end
        cpu_read(1'b1, v);
        checks++;
        if (v !== (32'h4B | BUILD)) begin errors++; $display("FAIL ovf_status_set: got %h want %h", v, 32'h4B | BUILD); end
        cpu_read(1'b1, v);
        checks++;
        if (v !== (32'h43 | BUILD)) begin errors++; $display("FAIL ovf_status_clear: got %h want %h", v, 32'h43 | BUILD); end
        wait_frames(5, 5 * FRAME + 40);
        repeat (2 * FRAME) @(posedge cpuclk);
        #2;
        checks++;
        if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_frames: got %0d want 5", rx_q.size()); end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (f.data !== e || f.framing_ok !== 1'b1) begin
                errors++; $display("FAIL ovf_data: got %h framing %b want %h", f.data, f.framing_ok, e);
            end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_push_pop_full();
        logic [31:0] v;
        int s;
        frame_t f;
        logic [7:0] e;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            cpu_write(1'b0, 8'h20 + 8'(i));
            if (i == 0) s = cyc + 1;
        end
        cpu_read(1'b1, v);
        checks++;
        if (v !== (32'h43 | BUILD)) begin errors++; $display("FAIL ppf_full_before: got %h want %h", v, 32'h43 | BUILD); end
        while (cyc < s + FRAME - 1) begin
            @(posedge cpuclk); #1;
        end
        exp_q.push_back(8'h25);
        cpu_write(1'b0, 8'h25);
        cpu_read(1'b1, v);
        checks++;
        if (v !== (32'h43 | BUILD)) begin errors++; $display("FAIL ppf_status_after: got %h want %h", v, 32'h43 | BUILD); end
        wait_frames(6, 6 * FRAME + 40);
        checks++;
        if (rx_q.size() != 6) begin errors++; $display("FAIL ppf_frames: got %0d want 6", rx_q.size()); end
        if (rx_q.size() > 1) begin
            checks++;
            if (rx_q[1].start != s + FRAME) begin
                errors++; $display("FAIL ppf_chain: got %0d want %0d", rx_q[1].start, s + FRAME);
            end
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (f.data !== e) begin errors++; $display("FAIL ppf_data: got %h want %h", f.data, e); end
        end
        rx_q.delete(); exp_q.delete();
        wait_not_busy(FRAME + 20);
    endtask

    task automatic test_reset_mid_frame();
        int s;
        int lows;
        cpu_write(1'b0, 8'hFF);
        s = cyc + 1;
        cpu_write(1'b0, 8'h11);
        cpu_write(1'b0, 8'h22);
        while (cyc < s + 3 * CPB - 1) begin
            @(posedge cpuclk); #1;
        end
        @(negedge cpuclk);
        rst = 1'b1;
        bus.io_addr = 1'b1;
        @(posedge cpuclk); #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
        checks++;
        if (bus.io_rdata !== (32'h4 | BUILD)) begin
            errors++; $display("FAIL rst_mid_status: got %h want %h", bus.io_rdata, 32'h4 | BUILD);
        end
        @(negedge cpuclk);
        rst = 1'b0;
        idle_bus();
        lows = 0;
        repeat (3 * FRAME) begin
            @(posedge cpuclk); #1;
            if (tx !== 1'b1) lows++;
        end
        #1;
        checks++;
        if (lows != 0 || rx_q.size() != 0) begin
            errors++; $display("FAIL rst_mid_quiet: got %0d low cycles %0d frames want 0 0", lows, rx_q.size());
        end
        rx_q.delete();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [31:0] v;
        frame_t f;
        cpu_write(1'b0, 8'h07);
        wait_frames(1, FRAME + 20);
        checks++;
        if (rx_q.size() != 1) begin
            errors++; $display("FAIL par_count: got %0d want 1", rx_q.size());
        end else begin
            f = rx_q.pop_front();
            checks++;
            if (f.data !== 8'h07 || f.par !== 1'b1) begin
                errors++; $display("FAIL par_bit: got data %h par %b want 07 1", f.data, f.par);
            end
            wait_not_busy(FRAME + 20);
            checks++;
            if (cyc != f.start + 44) begin errors++; $display("FAIL par_len: got %0d want %0d", cyc, f.start + 44); end
        end
        cpu_read(1'b1, v);
        checks++;
        if (v[31] !== 1'b1) begin errors++; $display("FAIL par_status31: got %b want 1", v[31]); end
    endtask
`endif

    initial begin : main
        idle_bus();
        test_reset();
        test_status_write_ignored();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
